tilelink_ul_slave: RTL and testbench



---
 rtl/tilelink_ul_pkg.sv | 26 ++
 rtl/tilelink_ul_mem.sv | 31 +++
 rtl/tilelink_ul_slave.sv | 143 ++++++++++++++
 tb/tb_tilelink_ul_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tilelink_ul_pkg.sv
// tilelink_ul_pkg: shared TL-UL opcodes, default widths and FSM states
// for the tilelink_ul_slave scratchpad endpoint.
package tilelink_ul_pkg;

  localparam int DEF_ADDR_W   = 64;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_SRC_W    = 3;
  localparam int DEF_SINK_W   = 3;
  localparam int DEF_OP_W     = 3;
  localparam int DEF_PARAM_W  = 3;
  localparam int DEF_SIZE_W   = 8;
  localparam int DEF_DEPTH    = 256;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;

  localparam logic [2:0] D_ACK         = 3'd0;
  localparam logic [2:0] D_ACK_DATA    = 3'd1;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } tl_state_e;

endpackage

// File: rtl/tilelink_ul_mem.sv
// tilelink_ul_mem: byte-masked RAM, synchronous write, asynchronous read.
// Contents are intentionally not reset.
module tilelink_ul_mem #(
  parameter int DEPTH = 256,
  parameter int DW    = 64,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_idx,
  input  logic [DW/8-1:0] i_mask,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // write only the bytes selected by the mask
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_mask[b]) begin
          r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/tilelink_ul_slave.sv
// tilelink_ul_slave: single-outstanding TL-UL slave over a scratchpad RAM.
// Define TL_UL_SLAVE_ADDR_CHECK_EN to flag addresses above the RAM range.
module tilelink_ul_slave
  import tilelink_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = DEF_ADDR_W,
  parameter int TL_DATA_WIDTH   = DEF_DATA_W,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH/8,
  parameter int TL_SOURCE_WIDTH = DEF_SRC_W,
  parameter int TL_SINK_WIDTH   = DEF_SINK_W,
  parameter int TL_OPCODE_WIDTH = DEF_OP_W,
  parameter int TL_PARAM_WIDTH  = DEF_PARAM_W,
  parameter int TL_SIZE_WIDTH   = DEF_SIZE_W,
  parameter int MEM_DEPTH       = DEF_DEPTH,
  parameter int SINK_ID         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
);

  localparam int OFFW = $clog2(TL_STRB_WIDTH);
  localparam int IDXW = $clog2(MEM_DEPTH);

  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PF = TL_OPCODE_WIDTH'(A_PUT_FULL);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PP = TL_OPCODE_WIDTH'(A_PUT_PARTIAL);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_GT = TL_OPCODE_WIDTH'(A_GET);

  tl_state_e                    r_state;
  logic                         r_d_valid;
  logic [TL_OPCODE_WIDTH-1:0]   r_d_opcode;
  logic [TL_SIZE_WIDTH-1:0]     r_d_size;
  logic [TL_SOURCE_WIDTH-1:0]   r_d_source;
  logic [TL_DATA_WIDTH-1:0]     r_d_data;
  logic                         r_d_error;

  logic [IDXW-1:0]              w_idx;
  logic                         w_is_put;
  logic                         w_is_get;
  logic                         w_size_err;
  logic                         w_addr_err;
  logic                         w_err;
  logic                         w_we;
  logic [TL_DATA_WIDTH-1:0]     w_rdata;
  logic                         w_unused;

  assign w_idx      = a_address[OFFW +: IDXW];
  assign w_is_put   = (a_opcode == OP_PF) || (a_opcode == OP_PP);
  assign w_is_get   = (a_opcode == OP_GT);
  assign w_size_err = a_size > TL_SIZE_WIDTH'(OFFW);

`ifdef TL_UL_SLAVE_ADDR_CHECK_EN
  assign w_addr_err = |(a_address >> (OFFW + IDXW));
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_err    = !(w_is_put || w_is_get) || w_size_err || w_addr_err;
  assign a_ready  = rst && (r_state == ST_IDLE);
  assign w_we     = a_valid && a_ready && w_is_put && !w_err;
  assign w_unused = ^{a_param, a_address};

  tilelink_ul_mem #(
    .DEPTH (MEM_DEPTH),
    .DW    (TL_DATA_WIDTH),
    .IDXW  (IDXW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_mask  (a_mask),
    .i_wdata (a_data),
    .o_rdata (w_rdata)
  );

  // handshake FSM: capture the response on accept, hold it until d_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (a_valid) begin
            r_state    <= ST_RESP;
            r_d_valid  <= 1'b1;
            r_d_size   <= a_size;
            r_d_source <= a_source;
            r_d_error  <= w_err;
            if (w_is_get) begin
              r_d_opcode <= TL_OPCODE_WIDTH'(D_ACK_DATA);
              r_d_data   <= w_err ? '0 : w_rdata;
            end else begin
              r_d_opcode <= TL_OPCODE_WIDTH'(D_ACK);
            end
          end
        end
        ST_RESP: begin
          if (d_ready) begin
            r_state   <= ST_IDLE;
            r_d_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_d_valid <= 1'b0;
        end
      endcase
    end
  end

  assign d_valid  = r_d_valid;
  assign d_opcode = r_d_opcode;
  assign d_param  = '0;
  assign d_size   = r_d_size;
  assign d_sink   = TL_SINK_WIDTH'(SINK_ID);
  assign d_source = r_d_source;
  assign d_data   = r_d_data;
  assign d_error  = r_d_error;

endmodule

// File: tb/tb_tilelink_ul_slave.sv
// tb_tilelink_ul_slave: directed vector bench for tilelink_ul_slave.
// Table of transactions plus stall and reset-in-RESP sequences.
module tb_tilelink_ul_slave;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [63:0] a_address;
  logic [7:0]  a_size;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic [2:0]  a_source;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink;
  logic [2:0]  d_source;
  logic [63:0] d_data;
  logic        d_error;

  tilelink_ul_slave dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_address (a_address),
    .a_size    (a_size),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_source  (a_source),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_sink    (d_sink),
    .d_source  (d_source),
    .d_data    (d_data),
    .d_error   (d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  size;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  src;
    logic [2:0]  eop;
    logic [63:0] edata;
    logic        eerr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_data = '0;
  vec_t        tbl [13];

  function automatic vec_t mk(
    input logic [2:0]  op,
    input logic [63:0] addr,
    input logic [7:0]  size,
    input logic [7:0]  mask,
    input logic [63:0] data,
    input logic [2:0]  src,
    input logic [2:0]  eop,
    input logic [63:0] edata,
    input logic        eerr
  );
    vec_t v;
    v.op = op; v.addr = addr; v.size = size;
    v.mask = mask; v.data = data; v.src = src;
    v.eop = eop; v.edata = edata; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(
    input string       n,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input int stall);
    logic [63:0] ed;
    @(negedge clk);
    chk("a_ready_idle", 64'(a_ready), 64'd1);
    a_opcode  = v.op;
    a_address = v.addr;
    a_size    = v.size;
    a_mask    = v.mask;
    a_data    = v.data;
    a_source  = v.src;
    a_param   = 3'd5;
    a_valid   = 1'b1;
    d_ready   = 1'b0;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk("d_valid_lat", 64'(d_valid), 64'd1);
    chk("a_ready_resp", 64'(a_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      a_opcode  = 3'd0;
      a_data    = '0;
      a_mask    = 8'hFF;
      a_valid   = 1'b1;
      chk("stall_d_valid", 64'(d_valid), 64'd1);
      chk("stall_a_ready", 64'(a_ready), 64'd0);
      chk("stall_src", 64'(d_source), 64'(v.src));
      chk("stall_op", 64'(d_opcode), 64'(v.eop));
    end
    @(negedge clk);
    a_valid = 1'b0;
    ed = (v.eop == 3'd1) ? v.edata : last_data;
    chk("d_valid", 64'(d_valid), 64'd1);
    chk("d_opcode", 64'(d_opcode), 64'(v.eop));
    chk("d_error", 64'(d_error), 64'(v.eerr));
    chk("d_source", 64'(d_source), 64'(v.src));
    chk("d_size", 64'(d_size), 64'(v.size));
    chk("d_param", 64'(d_param), 64'd0);
    chk("d_sink", 64'(d_sink), 64'd0);
    chk("d_data", d_data, ed);
    last_data = ed;
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    chk("d_valid_done", 64'(d_valid), 64'd0);
    chk("a_ready_done", 64'(a_ready), 64'd1);
    chk("d_data_hold", d_data, ed);
  endtask

  initial begin
    rst = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = '0; a_param = '0; a_address = '0; a_size = '0;
    a_mask = '0; a_data = '0; a_source = '0;

    tbl[0]  = mk(3'd0, 64'h10, 8'd3, 8'hFF, 64'hDEADBEEFCAFEBABE,
                 3'd1, 3'd0, 64'h0, 1'b0);
    tbl[1]  = mk(3'd4, 64'h10, 8'd3, 8'h00, 64'h0,
                 3'd2, 3'd1, 64'hDEADBEEFCAFEBABE, 1'b0);
    tbl[2]  = mk(3'd0, 64'h20, 8'd3, 8'hFF, 64'h0,
                 3'd3, 3'd0, 64'h0, 1'b0);
    tbl[3]  = mk(3'd1, 64'h20, 8'd3, 8'h0F, 64'h123456789ABCDEF0,
                 3'd4, 3'd0, 64'h0, 1'b0);
    tbl[4]  = mk(3'd4, 64'h20, 8'd3, 8'h01, 64'h0,
                 3'd5, 3'd1, 64'h000000009ABCDEF0, 1'b0);
    tbl[5]  = mk(3'd2, 64'h10, 8'd3, 8'hFF, 64'h0,
                 3'd6, 3'd0, 64'h0, 1'b1);
    tbl[6]  = mk(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0,
                 3'd7, 3'd1, 64'hDEADBEEFCAFEBABE, 1'b0);
    tbl[7]  = mk(3'd4, 64'h10, 8'd4, 8'hFF, 64'h0,
                 3'd0, 3'd1, 64'h0, 1'b1);
    tbl[8]  = mk(3'd4, 64'h17, 8'd2, 8'hFF, 64'h0,
                 3'd1, 3'd1, 64'hDEADBEEFCAFEBABE, 1'b0);
    tbl[9]  = mk(3'd1, 64'h10, 8'd3, 8'h81, 64'h1111111111111111,
                 3'd2, 3'd0, 64'h0, 1'b0);
    tbl[10] = mk(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0,
                 3'd3, 3'd1, 64'h11ADBEEFCAFEBA11, 1'b0);
    tbl[11] = mk(3'd0, 64'h0, 8'd3, 8'hFF, 64'hA5A5A5A5A5A5A5A5,
                 3'd4, 3'd0, 64'h0, 1'b0);
`ifdef TL_UL_SLAVE_ADDR_CHECK_EN
    tbl[12] = mk(3'd4, 64'h10000, 8'd3, 8'hFF, 64'h0,
                 3'd5, 3'd1, 64'h0, 1'b1);
`else
    tbl[12] = mk(3'd4, 64'h10000, 8'd3, 8'hFF, 64'h0,
                 3'd5, 3'd1, 64'hA5A5A5A5A5A5A5A5, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_error", 64'(d_error), 64'd0);
    chk("rst_d_sink", 64'(d_sink), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_a_ready", 64'(a_ready), 64'd1);

    for (int i = 0; i < 13; i++) txn(tbl[i], 0);

    txn(mk(3'd0, 64'h30, 8'd3, 8'hFF, 64'hBADDCAFEBEEF1234,
           3'd5, 3'd0, 64'h0, 1'b0), 3);
    txn(mk(3'd4, 64'h30, 8'd3, 8'hFF, 64'h0,
           3'd6, 3'd1, 64'hBADDCAFEBEEF1234, 1'b0), 2);

    @(negedge clk);
    a_opcode = 3'd4; a_address = 64'h10; a_size = 8'd3;
    a_source = 3'd7; a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk("pre_rst_d_valid", 64'(d_valid), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_d_valid", 64'(d_valid), 64'd0);
    chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
    chk("mid_rst_d_data", d_data, 64'd0);
    chk("mid_rst_d_src", 64'(d_source), 64'd0);
    chk("mid_rst_d_size", 64'(d_size), 64'd0);
    chk("mid_rst_d_op", 64'(d_opcode), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    last_data = '0;
    txn(mk(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0,
           3'd1, 3'd1, 64'h11ADBEEFCAFEBA11, 1'b0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
